vdp_sprite_linebuf: RTL

Double-buffered sprite line buffer for the VDP sprite path.
- The sprite fetch stage writes up to SPR_SLOTS decoded sprite rows for the next scanline: horizontal position plus four 8-bit bitplanes.
- During the current scanline the block serializes the previously filled bank into one 4-bit sprite colour per pixel.
- It also reports sprite-collision and sprite-overflow status to the register/status logic.
- The background/pixel mixer consumes its output.

---
 rtl/vdp_pkg.sv | 19 +
 rtl/vdp_sprite_entry_decode.sv | 35 +++
 rtl/vdp_sprite_linebuf.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_pkg : shared VDP types and constants for the sprite path
// Revision: 1.0
// ---------------------------------------------------------------------------
package vdp_pkg;

   localparam int SPR_PER_LINE = 8;

   typedef struct packed {
      logic            valid;
      logic [7:0]      hpos;
      logic [3:0][7:0] planes;
   } spr_entry_t;

   localparam logic [3:0] SPR_TRANSPARENT = 4'd0;

endpackage
`default_nettype wire

// File: rtl/vdp_sprite_entry_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_sprite_entry_decode : hit test and colour lookup for one sprite entry
// Revision: 1.0
// ---------------------------------------------------------------------------
module vdp_sprite_entry_decode
   import vdp_pkg::*;
(
   input  spr_entry_t entry,
   input  logic [7:0] pix_x,
   output logic       hit,
   output logic [3:0] colour,
   output logic       opaque
);

   logic [8:0] d;
   logic [2:0] b;

   // 9-bit difference so a pixel left of the sprite shows up as negative
   assign d   = {1'b0, pix_x} - {1'b0, entry.hpos};
   assign hit = entry.valid && !d[8] && (d[7:3] == 5'd0);
   assign b   = 3'd7 - d[2:0];

   always_comb begin
      colour = SPR_TRANSPARENT;
      if (hit) begin
         colour = {entry.planes[3][b], entry.planes[2][b],
                   entry.planes[1][b], entry.planes[0][b]};
      end
   end

   assign opaque = hit && (colour != SPR_TRANSPARENT);

endmodule
`default_nettype wire

// File: rtl/vdp_sprite_linebuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vdp_sprite_linebuf : double-buffered sprite line buffer with collision and
// overflow status.  Revision: 1.0
// ---------------------------------------------------------------------------
module vdp_sprite_linebuf
   import vdp_pkg::*;
#(
   parameter int SPR_SLOTS = SPR_PER_LINE
)(
   input  logic                         clk,
   input  logic                         rst_L,
   input  logic                         line_swap,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [7:0]                   wr_hpos,
   input  logic [3:0][7:0]              wr_planes,
   input  logic                         pix_en,
   input  logic [7:0]                   pix_x,
   output logic                         spr_valid,
   output logic [3:0]                   spr_color,
   input  logic                         status_clr,
   output logic                         collision,
   output logic                         overflow,
   output logic [$clog2(SPR_SLOTS):0]   fill_count
);

   localparam int IW = $clog2(SPR_SLOTS);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] SLOTS_C = CW'(SPR_SLOTS);

   spr_entry_t       bank_q [2][SPR_SLOTS];
   spr_entry_t       bank_d [2][SPR_SLOTS];
   logic             disp_sel_q, disp_sel_d;
   logic [CW-1:0]    fill_count_q, fill_count_d;
   logic             spr_valid_q, spr_valid_d;
   logic [3:0]       spr_color_q, spr_color_d;
   logic             collision_q, collision_d;
   logic             overflow_q, overflow_d;

   spr_entry_t       disp_entry [SPR_SLOTS];
   logic [SPR_SLOTS-1:0] ent_hit;
   logic [SPR_SLOTS-1:0] ent_opaque;
   logic [3:0]       ent_colour [SPR_SLOTS];

   logic             fill_sel;
   logic [CW-1:0]    cnt;
   logic             win_found;
   logic [3:0]       win_col;
   logic             any_opaque;
   logic             multi_opaque;

   // Fill side: a coincident swap is applied before the write lands
   always_comb begin
      bank_d       = bank_q;
      disp_sel_d   = disp_sel_q;
      fill_sel     = ~disp_sel_q;
      cnt          = fill_count_q;
      overflow_d   = overflow_q;
      if (status_clr) overflow_d = 1'b0;
      if (line_swap) begin
         disp_sel_d = ~disp_sel_q;
         fill_sel   = disp_sel_q;
         cnt        = '0;
         for (int i = 0; i < SPR_SLOTS; i++) begin
            bank_d[fill_sel][i].valid = 1'b0;
         end
      end
      if (wr_valid) begin
         if (cnt < SLOTS_C) begin
            bank_d[fill_sel][cnt[IW-1:0]] = '{valid: 1'b1, hpos: wr_hpos, planes: wr_planes};
            cnt = cnt + CW'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end
      fill_count_d = cnt;
   end

   always_comb begin
      for (int i = 0; i < SPR_SLOTS; i++) begin
         disp_entry[i] = bank_q[disp_sel_q][i];
      end
   end

   generate
      for (genvar g = 0; g < SPR_SLOTS; g++) begin : g_entry
         vdp_sprite_entry_decode u_dec (
            .entry  (disp_entry[g]),
            .pix_x  (pix_x),
            .hit    (ent_hit[g]),
            .colour (ent_colour[g]),
            .opaque (ent_opaque[g])
         );
      end
   endgenerate

   // Lowest index wins: scan from the top so the last assignment is the winner
   always_comb begin
      win_found    = 1'b0;
      win_col      = SPR_TRANSPARENT;
      any_opaque   = 1'b0;
      multi_opaque = 1'b0;
      for (int i = SPR_SLOTS - 1; i >= 0; i--) begin
         if (ent_hit[i] && ent_opaque[i]) begin
            win_found = 1'b1;
            win_col   = ent_colour[i];
            if (any_opaque) multi_opaque = 1'b1;
            any_opaque = 1'b1;
         end
      end
   end

   always_comb begin
      spr_valid_d = 1'b0;
      spr_color_d = spr_color_q;
      collision_d = collision_q;
      if (pix_en) begin
         spr_valid_d = win_found;
         spr_color_d = win_col;
      end
      if (status_clr) collision_d = 1'b0;
      if (pix_en && multi_opaque) collision_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < SPR_SLOTS; i++) begin
               bank_q[s][i] <= '0;
            end
         end
         disp_sel_q   <= 1'b0;
         fill_count_q <= '0;
         spr_valid_q  <= 1'b0;
         spr_color_q  <= SPR_TRANSPARENT;
         collision_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         bank_q       <= bank_d;
         disp_sel_q   <= disp_sel_d;
         fill_count_q <= fill_count_d;
         spr_valid_q  <= spr_valid_d;
         spr_color_q  <= spr_color_d;
         collision_q  <= collision_d;
         overflow_q   <= overflow_d;
      end
   end

   assign wr_ready   = (fill_count_q < SLOTS_C);
   assign fill_count = fill_count_q;
   assign spr_valid  = spr_valid_q;
   assign spr_color  = spr_color_q;
   assign collision  = collision_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire
